// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction-fetch stage with IF/ID register; PC, one-outstanding imem fetch, redirect squash, stall skid.
// Latency: request accepted in cycle N, response in N+k (k>=1), instruction on IF/ID from N+k+1; 1 instr/cycle at k=1.
// Backpressure: stall freezes IF/ID and parks at most one response in a skid buffer; no new request while it is full.
// Ports: clock/reset_n; stall, pc_src/jump_address from hazard unit and decode;
//        imem_req/imem_addr/imem_ready request side, imem_rvalid/imem_rdata response side;
//        instruction/pc_plus_four/valid_D IF/ID outputs, pc_F current fetch PC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_four,
  output logic        valid_D,
  output logic [31:0] pc_F
);

  typedef enum logic {ST_ISSUE = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc4_q, req_pc4_d;
  logic        drop_q, drop_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        issue_ok;
  logic        accept;
  logic        resp;
  logic        resp_drop;
  logic        resp_live;
  logic [31:0] pc_inc;
  logic [31:0] jump_tgt;

  // A stalled decode cannot consume a redirect, so it only takes effect when not stalled.
  assign redirect  = pc_src && !stall;
  assign accept    = imem_req && imem_ready;
  assign resp      = (state_q == ST_WAIT) && imem_rvalid;
  // Wrong-path responses: either marked earlier by drop, or overtaken by a redirect this cycle.
  assign resp_drop = resp && (drop_q || redirect);
  assign resp_live = resp && !resp_drop;
  assign pc_inc    = pc_q + 32'd4;
  assign jump_tgt  = jump_address & 32'hFFFF_FFFC;

  assign imem_addr    = pc_q;
  assign pc_F         = pc_q;
  assign instruction  = instr_q;
  assign pc_plus_four = pc4_q;
  assign valid_D      = valid_q;

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_WAIT;
    end else if (resp) begin
      state_d = ST_ISSUE;
    end
  end

  // FSM: outputs. In WAIT the next request may go out in the same cycle the
  // response lands, provided that response has somewhere to go (or is dropped).
  always_comb begin
    issue_ok = 1'b0;
    if (!buf_valid_q) begin
      if (state_q == ST_ISSUE) begin
        issue_ok = 1'b1;
      end else begin
        issue_ok = imem_rvalid && (drop_q || !stall);
      end
    end
    imem_req = reset_n && issue_ok;
  end

  // PC, request tag, drop flag, skid buffer and IF/ID next-state
  always_comb begin
    pc_d        = pc_q;
    req_pc4_d   = req_pc4_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    if (accept) begin
      req_pc4_d = pc_inc;
      pc_d      = redirect ? jump_tgt : pc_inc;
    end else if (redirect) begin
      pc_d = jump_tgt;
    end

    if (resp_drop) begin
      drop_d = 1'b0;
    end
    // A request left in flight by a redirect (just accepted, or still pending) must be discarded on return.
    if (redirect && (accept || ((state_q == ST_WAIT) && !imem_rvalid))) begin
      drop_d = 1'b1;
    end

    if (!stall) begin
      if (redirect) begin
        instr_d     = 32'd0;
        pc4_d       = 32'd0;
        valid_d     = 1'b0;
        buf_valid_d = 1'b0;
      end else if (buf_valid_q) begin
        instr_d     = buf_instr_q;
        pc4_d       = buf_pc4_q;
        valid_d     = 1'b1;
        buf_valid_d = 1'b0;
      end else if (resp_live) begin
        instr_d = imem_rdata;
        pc4_d   = req_pc4_q;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'd0;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
    end else if (resp_live && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem_rdata;
      buf_pc4_d   = req_pc4_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      req_pc4_q   <= 32'd0;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc4_q   <= req_pc4_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural memory (rdata = address), cycle table after reset,
// in-order scoreboard of delivered instructions, PC model, and corner sequences.
module tb_fetch_stage;

  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] jump_address = 32'd0;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic [31:0] pc_plus_four;
  logic        valid_D;
  logic [31:0] pc_F;

  logic        req_b;
  logic [31:0] addr_b;
  logic [31:0] instr_b;
  logic [31:0] pc4_b;
  logic        valid_b;
  logic [31:0] pcf_b;

  always #5 clock = ~clock;

  fetch_stage u_dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .pc_src(pc_src),
    .jump_address(jump_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_plus_four(pc_plus_four), .valid_D(valid_D), .pc_F(pc_F)
  );

  fetch_stage #(.RESET_PC(RPC2)) u_dut_wrap (
    .clock(clock), .reset_n(reset_n), .stall(stall), .pc_src(pc_src),
    .jump_address(jump_address), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instr_b), .pc_plus_four(pc4_b), .valid_D(valid_b), .pc_F(pcf_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 1;
  int acc_count = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  mreq_t mq[$];
  exp_t  exp_q[$];

  // Memory response driver: one word per accepted request, mem_lat cycles later.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: memory bookkeeping, PC model, scoreboard of IF/ID deliveries.
  logic        prev_ok = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_redirect = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_pc4 = 32'd0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_pc = RPC;

  initial begin
    exp_t        e;
    logic        redir;
    logic [31:0] tgt;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete();
        mq.delete();
        prev_ok = 1'b0;
        exp_pc  = RPC;
      end else begin
        if (prev_ok) begin
          if (prev_stall) begin
            chk("stall_frozen_instr", instruction, prev_instr);
            chk("stall_frozen_pc4", pc_plus_four, prev_pc4);
            chk("stall_frozen_valid", 32'(valid_D), 32'(prev_valid));
          end else if (prev_redirect) begin
            chk("redirect_bubble_valid", 32'(valid_D), 32'd0);
            chk("redirect_bubble_instr", instruction, 32'd0);
          end else if (valid_D) begin
            if (exp_q.size() == 0) begin
              chk("sb_unexpected_instr", 32'(valid_D), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("sb_instr", instruction, e.instr);
              chk("sb_pc4", pc_plus_four, e.pc4);
            end
          end else begin
            chk("bubble_zero", instruction | pc_plus_four, 32'd0);
          end
          if (prev_req && !prev_ready && !prev_redirect) begin
            chk("unaccepted_req_held", 32'(imem_req), 32'd1);
            chk("unaccepted_addr_held", imem_addr, prev_addr);
          end
        end
        if (imem_rvalid && mq.size() > 0) mq.delete(0);
        redir = pc_src && !stall;
        tgt   = jump_address & 32'hFFFF_FFFC;
        if (imem_req && imem_ready) begin
          chk("fetch_addr", imem_addr, exp_pc);
          chk("one_outstanding", 32'(mq.size()), 32'd0);
          mq.push_back('{imem_addr, cyc + mem_lat});
          acc_count++;
          if (!redir) exp_q.push_back('{imem_addr, imem_addr + 32'd4});
          exp_pc = redir ? tgt : exp_pc + 32'd4;
        end else if (redir) begin
          exp_pc = tgt;
        end
        if (redir) exp_q.delete();
        prev_ok       = 1'b1;
        prev_stall    = stall;
        prev_redirect = redir;
        prev_req      = imem_req;
        prev_ready    = imem_ready;
        prev_addr     = imem_addr;
        prev_instr    = instruction;
        prev_pc4      = pc_plus_four;
        prev_valid    = valid_D;
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic [31:0] jump;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] j, input logic r,
                              input logic [31:0] a, input logic v, input logic [31:0] ins,
                              input logic [31:0] p4);
    vec_t t;
    t.stall = s; t.pc_src = p; t.jump = j; t.req = r;
    t.addr = a; t.valid = v; t.instr = ins; t.pc4 = p4;
    return t;
  endfunction

  initial begin
    vec_t tbl [20];
    int   a0;
    logic found;

    // Cycle table from reset release, 1-cycle memory, ready always high.
    tbl[0]  = mk(0, 0, 32'd0,         1, 32'h0040_0000, 0, 32'd0,         32'd0);
    tbl[1]  = mk(0, 0, 32'd0,         1, 32'h0040_0004, 0, 32'd0,         32'd0);
    tbl[2]  = mk(0, 0, 32'd0,         1, 32'h0040_0008, 1, 32'h0040_0000, 32'h0040_0004);
    tbl[3]  = mk(0, 0, 32'd0,         1, 32'h0040_000C, 1, 32'h0040_0004, 32'h0040_0008);
    tbl[4]  = mk(0, 0, 32'd0,         1, 32'h0040_0010, 1, 32'h0040_0008, 32'h0040_000C);
    tbl[5]  = mk(1, 0, 32'd0,         0, 32'h0040_0014, 1, 32'h0040_000C, 32'h0040_0010);
    tbl[6]  = mk(1, 0, 32'd0,         0, 32'h0040_0014, 1, 32'h0040_000C, 32'h0040_0010);
    tbl[7]  = mk(1, 0, 32'd0,         0, 32'h0040_0014, 1, 32'h0040_000C, 32'h0040_0010);
    tbl[8]  = mk(0, 0, 32'd0,         0, 32'h0040_0014, 1, 32'h0040_000C, 32'h0040_0010);
    tbl[9]  = mk(0, 0, 32'd0,         1, 32'h0040_0014, 1, 32'h0040_0010, 32'h0040_0014);
    tbl[10] = mk(0, 0, 32'd0,         1, 32'h0040_0018, 0, 32'd0,         32'd0);
    tbl[11] = mk(0, 0, 32'd0,         1, 32'h0040_001C, 1, 32'h0040_0014, 32'h0040_0018);
    tbl[12] = mk(0, 1, 32'h0040_0103, 1, 32'h0040_0020, 1, 32'h0040_0018, 32'h0040_001C);
    tbl[13] = mk(0, 0, 32'd0,         1, 32'h0040_0100, 0, 32'd0,         32'd0);
    tbl[14] = mk(0, 0, 32'd0,         1, 32'h0040_0104, 0, 32'd0,         32'd0);
    tbl[15] = mk(0, 0, 32'd0,         1, 32'h0040_0108, 1, 32'h0040_0100, 32'h0040_0104);
    tbl[16] = mk(1, 1, 32'h0050_0000, 0, 32'h0040_010C, 1, 32'h0040_0104, 32'h0040_0108);
    tbl[17] = mk(0, 0, 32'd0,         0, 32'h0040_010C, 1, 32'h0040_0104, 32'h0040_0108);
    tbl[18] = mk(0, 0, 32'd0,         1, 32'h0040_010C, 1, 32'h0040_0108, 32'h0040_010C);
    tbl[19] = mk(0, 0, 32'd0,         1, 32'h0040_0110, 0, 32'd0,         32'd0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_pc_F", pc_F, RPC);
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_pc4", pc_plus_four, 32'd0);
    chk("reset_valid", 32'(valid_D), 32'd0);
    chk("reset_pc_F_wrap", pcf_b, RPC2);

    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) reset_n = 1'b1;
      stall        = tbl[i].stall;
      pc_src       = tbl[i].pc_src;
      jump_address = tbl[i].jump;
      @(negedge clock);
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_pc_F", i), pc_F, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 32'(valid_D), 32'(tbl[i].valid));
      chk($sformatf("row%0d_instr", i), instruction, tbl[i].instr);
      chk($sformatf("row%0d_pc4", i), pc_plus_four, tbl[i].pc4);
      if (i == 0) chk("wrap_first_addr", addr_b, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_second_addr", addr_b, 32'h0000_0000);
      if (i == 2) begin
        chk("wrap_pc4", pc4_b, 32'h0000_0000);
        chk("wrap_valid", 32'(valid_b), 32'd1);
        chk("wrap_third_addr", addr_b, 32'h0000_0004);
      end
    end

    // 3-cycle memory with ready low two cycles out of four.
    @(posedge clock);
    #1;
    stall   = 1'b0;
    pc_src  = 1'b0;
    mem_lat = 3;
    for (int k = 0; k < 40; k++) begin
      imem_ready = ((k % 4) < 2) ? 1'b0 : 1'b1;
      @(posedge clock);
      #1;
    end

    // Throughput with latency 3 and ready high: one accept every 3 cycles.
    imem_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    a0 = acc_count;
    repeat (12) @(posedge clock);
    #1;
    chk("lat3_throughput", 32'(acc_count - a0), 32'd4);

    imem_ready = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("drain_lat3", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset pulse while waiting for a response.
    imem_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (!imem_req && pc_F != RPC) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_state_timeout: got no WAIT cycle required one within 20 cycles");
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc_F", pc_F, RPC);
    chk("arst_instr", instruction, 32'd0);
    chk("arst_pc4", pc_plus_four, 32'd0);
    chk("arst_valid", 32'(valid_D), 32'd0);
    chk("arst_wrap_pc_F", pcf_b, RPC2);
    chk("arst_wrap_req", 32'(req_b), 32'd0);
    chk("arst_wrap_ifid", instr_b | pc4_b | 32'(valid_b), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    mem_lat = 1;
    reset_n = 1'b1;

    // Random stress: stalls, redirects, ready gaps, varying latency.
    for (int k = 0; k < 300; k++) begin
      stall        = ($urandom_range(0, 3) == 0);
      pc_src       = ($urandom_range(0, 5) == 0);
      jump_address = $urandom;
      imem_ready   = ($urandom_range(0, 3) != 0);
      mem_lat      = $urandom_range(1, 3);
      @(posedge clock);
      #1;
    end
    stall      = 1'b0;
    pc_src     = 1'b0;
    imem_ready = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("drain_random", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
